// File: rtl/citrus_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : citrus_irq_pkg
// Description : Shared constants, state encoding and helpers for the Citrus
//               interrupt request front-end.
//               Contents:
//                 NUM_IRQ / IRQ_ID_W : request line count and index width
//                 irq_state_t        : front-end state machine encoding
//                 IRQ_MASK_RST       : mask value after reset (all masked)
//                 IRQ_REQ_IDLE       : inactive level of the request vector
//                 irq_id_n_to_onehot : active-low index -> one-hot line mask
// Revision    : 1.0 - initial release
// ============================================================================
package citrus_irq_pkg;

    localparam int NUM_IRQ  = 8;
    localparam int IRQ_ID_W = 3;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_t;

    localparam logic [NUM_IRQ-1:0] IRQ_MASK_RST = 8'hFF;
    localparam logic [NUM_IRQ-1:0] IRQ_REQ_IDLE = 8'hFF;

    // The acknowledge carries the encoder's active-low index, so the line
    // being serviced is the bitwise inverse of the value on the bus.
    function automatic logic [NUM_IRQ-1:0] irq_id_n_to_onehot(
        input logic [IRQ_ID_W-1:0] id_n
    );
        logic [NUM_IRQ-1:0] w_one;
        w_one = {{(NUM_IRQ-1){1'b0}}, 1'b1};
        return w_one << (~id_n);
    endfunction

endpackage : citrus_irq_pkg
`default_nettype wire

// File: rtl/irq_sync.sv
`default_nettype none
// ============================================================================
// Module      : irq_sync
// Description : Single-bit multi-flop synchroniser for an asynchronous,
//               active-low request line. All stages reset to 1 so a line
//               reads as "no request" straight out of reset.
//               Ports:
//                 i_clk  : sampling clock
//                 i_rst  : synchronous active-high reset
//                 i_d    : asynchronous input
//                 o_q    : synchronised output (last stage)
//               Parameters:
//                 SYNC_STAGES : number of flops, 2 or more
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync_q <= '1;
        end else begin
            r_sync_q <= {r_sync_q[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync_q[SYNC_STAGES-1];

endmodule : irq_sync
`default_nettype wire

// File: rtl/irq_request_latch.sv
`default_nettype none
// ============================================================================
// Module      : irq_request_latch
// Description : Interrupt request front-end for the Citrus CPU. Synchronises
//               eight active-low device requests, latches them as pending,
//               applies a software mask and drives the active-low request
//               vector for the downstream 8-to-3 priority encoder. A CPU
//               acknowledge clears the serviced request and blocks further
//               requests until end-of-interrupt.
//               Ports:
//                 i_clk        : clock, rising edge
//                 i_rst        : synchronous active-high reset
//                 i_irq_n      : asynchronous requests, active-low, bit 7 highest
//                 i_mask_we    : mask write strobe
//                 i_mask_wdata : new mask, 1 = masked
//                 i_ack        : CPU acknowledge pulse
//                 i_ack_id_n   : active-low index sampled with i_ack
//                 i_eoi        : end-of-interrupt pulse
//                 o_req_n      : active-low request vector (registered)
//                 o_in_service : high while an interrupt is in service
//                 o_isr_id     : binary index of the line in service
//                 o_mask       : current mask
//               Configuration macro:
//                 IRQ_EDGE_TRIGGER_EN : defined  -> pending set on a
//                                       synchronised falling edge;
//                                       undefined -> level-sensitive.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_request_latch
    import citrus_irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NUM_IRQ-1:0]  i_irq_n,
    input  logic                i_mask_we,
    input  logic [NUM_IRQ-1:0]  i_mask_wdata,
    input  logic                i_ack,
    input  logic [IRQ_ID_W-1:0] i_ack_id_n,
    input  logic                i_eoi,
    output logic [NUM_IRQ-1:0]  o_req_n,
    output logic                o_in_service,
    output logic [IRQ_ID_W-1:0] o_isr_id,
    output logic [NUM_IRQ-1:0]  o_mask
);

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] w_sync;

    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
            irq_sync #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_irq_sync (
                .i_clk (i_clk),
                .i_rst (i_rst),
                .i_d   (i_irq_n[gi]),
                .o_q   (w_sync[gi])
            );
        end : g_sync
    endgenerate

    // ------------------------------------------------------------------
    // Capture events
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] w_set;

`ifdef IRQ_EDGE_TRIGGER_EN
    logic [NUM_IRQ-1:0] r_prev_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev_q <= '1;
        end else begin
            r_prev_q <= w_sync;
        end
    end

    // Only a 1->0 transition of the synchronised line requests service, so
    // a line held low after acknowledge does not request again.
    assign w_set = r_prev_q & ~w_sync;
`else
    // Level mode: a low line keeps re-setting its pending bit, including the
    // cycle right after an acknowledge cleared it.
    assign w_set = ~w_sync;
`endif

    // ------------------------------------------------------------------
    // State, pending, mask
    // ------------------------------------------------------------------
    irq_state_t            r_state_q;
    irq_state_t            w_state_d;
    logic [NUM_IRQ-1:0]    r_pend_q;
    logic [NUM_IRQ-1:0]    w_pend_d;
    logic [NUM_IRQ-1:0]    r_mask_q;
    logic [NUM_IRQ-1:0]    w_mask_d;
    logic [IRQ_ID_W-1:0]   r_isr_id_q;
    logic [IRQ_ID_W-1:0]   w_isr_id_d;
    logic [NUM_IRQ-1:0]    r_req_n_q;
    logic [NUM_IRQ-1:0]    w_req_n_d;
    logic                  r_in_service_q;
    logic [NUM_IRQ-1:0]    w_clr;
    logic [NUM_IRQ-1:0]    w_active;

    assign w_active = r_pend_q & ~r_mask_q;

    always_comb begin
        w_state_d  = r_state_q;
        w_isr_id_d = r_isr_id_q;
        w_clr      = '0;

        case (r_state_q)
            IRQ_IDLE: begin
                if (|w_active) begin
                    w_state_d = IRQ_REQ;
                end
            end
            IRQ_REQ: begin
                // An ack is taken even if its line is not pending (spurious
                // vector); the CPU still closes it with EOI.
                if (i_ack) begin
                    w_state_d  = IRQ_SERVICE;
                    w_clr      = irq_id_n_to_onehot(i_ack_id_n);
                    w_isr_id_d = ~i_ack_id_n;
                end else if (!(|w_active)) begin
                    w_state_d = IRQ_IDLE;
                end
            end
            IRQ_SERVICE: begin
                if (i_eoi) begin
                    w_state_d = (|w_active) ? IRQ_REQ : IRQ_IDLE;
                end
            end
            default: begin
                w_state_d = IRQ_IDLE;
            end
        endcase

        // A new capture in the same cycle as the clear wins.
        w_pend_d = (r_pend_q & ~w_clr) | w_set;
        w_mask_d = i_mask_we ? i_mask_wdata : r_mask_q;

        // The request vector is computed from next-state values and then
        // registered, so it never carries a combinational input path.
        if (w_state_d == IRQ_SERVICE) begin
            w_req_n_d = IRQ_REQ_IDLE;
        end else begin
            w_req_n_d = ~(w_pend_d & ~w_mask_d);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q      <= IRQ_IDLE;
            r_pend_q       <= '0;
            r_mask_q       <= IRQ_MASK_RST;
            r_isr_id_q     <= '0;
            r_req_n_q      <= IRQ_REQ_IDLE;
            r_in_service_q <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_pend_q       <= w_pend_d;
            r_mask_q       <= w_mask_d;
            r_isr_id_q     <= w_isr_id_d;
            r_req_n_q      <= w_req_n_d;
            r_in_service_q <= (w_state_d == IRQ_SERVICE);
        end
    end

    assign o_req_n      = r_req_n_q;
    assign o_in_service = r_in_service_q;
    assign o_isr_id     = r_isr_id_q;
    assign o_mask       = r_mask_q;

endmodule : irq_request_latch
`default_nettype wire

// File: tb/tb_irq_request_latch.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_request_latch
// Description : Self-checking bench for irq_request_latch. A transaction-level
//               reference model tracks the synchroniser delay as a sample
//               queue and the pending/mask/state rules as plain variables.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_request_latch;

    localparam int SYNC_STAGES = 2;

    logic       clk;
    logic       rst;
    logic [7:0] irq_n;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       ack;
    logic [2:0] ack_id_n;
    logic       eoi;
    logic [7:0] req_n;
    logic       in_service;
    logic [2:0] isr_id;
    logic [7:0] mask;

    int n_checks = 0;
    int n_errs   = 0;

    irq_request_latch #(
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_irq_n      (irq_n),
        .i_mask_we    (mask_we),
        .i_mask_wdata (mask_wdata),
        .i_ack        (ack),
        .i_ack_id_n   (ack_id_n),
        .i_eoi        (eoi),
        .o_req_n      (req_n),
        .o_in_service (in_service),
        .o_isr_id     (isr_id),
        .o_mask       (mask)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    logic [7:0] m_q[$];     // input samples still travelling through the synchroniser
    logic [7:0] m_prev;
    logic [7:0] m_pend;
    logic [7:0] m_mask;
    int         m_st;       // 0 idle, 1 requesting, 2 in service
    int         m_isr;

    task automatic model_step();
        logic [7:0] seen, set, act, clr;
        int idx;
        if (rst) begin
            m_q.delete();
            for (int i = 0; i < SYNC_STAGES; i++) m_q.push_back(8'hFF);
            m_prev = 8'hFF; m_pend = 8'h00; m_mask = 8'hFF; m_st = 0; m_isr = 0;
            return;
        end
        seen = m_q.pop_front();
        m_q.push_back(irq_n);
`ifdef IRQ_EDGE_TRIGGER_EN
        set = m_prev & ~seen;
`else
        set = ~seen;
`endif
        m_prev = seen;
        act = m_pend & ~m_mask;
        clr = 8'h00;
        if (m_st == 0) begin
            if (act != 0) m_st = 1;
        end else if (m_st == 1) begin
            if (ack) begin
                idx   = 7 - int'(ack_id_n);
                clr   = 8'h01 << idx;
                m_isr = idx;
                m_st  = 2;
            end else if (act == 0) begin
                m_st = 0;
            end
        end else begin
            if (eoi) m_st = (act != 0) ? 1 : 0;
        end
        m_pend = (m_pend & ~clr) | set;
        if (mask_we) m_mask = mask_wdata;
    endtask

    function automatic logic [19:0] model_vec();
        logic [7:0] r;
        r = (m_st == 2) ? 8'hFF : ~(m_pend & ~m_mask);
        return {r, (m_st == 2), 3'(m_isr), m_mask};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        irq_n = 8'hFF; mask_we = 0; ack = 0; eoi = 0; rst = 1;
        tick(); tick();
        rst = 0;
    endtask

    task automatic write_mask(input logic [7:0] v);
        mask_we = 1; mask_wdata = v;
        tick();
        mask_we = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1; irq_n = 8'h00;
        tick(); tick();
        n_checks++;
        if (req_n !== 8'hFF) begin n_errs++; $display("FAIL reset_req_n got %h exp ff", req_n); end
        n_checks++;
        if (mask !== 8'hFF) begin n_errs++; $display("FAIL reset_mask got %h exp ff", mask); end
        n_checks++;
        if (in_service !== 1'b0 || isr_id !== 3'd0) begin
            n_errs++; $display("FAIL reset_service got %b/%0d exp 0/0", in_service, isr_id);
        end
    endtask

    task automatic test_single_request();
        do_reset();
        write_mask(8'h00);
        irq_n[3] = 1'b0;
        tick(); tick();
        n_checks++;
        if (req_n !== 8'hFF) begin n_errs++; $display("FAIL single_early got %h exp ff", req_n); end
        tick();
        n_checks++;
        if (req_n !== 8'hF7) begin n_errs++; $display("FAIL single_latency got %h exp f7", req_n); end
        irq_n[3] = 1'b1;
        tick(); tick(); tick();
        ack = 1; ack_id_n = 3'b100;
        tick();
        ack = 0;
        n_checks++;
        if (req_n !== 8'hFF || isr_id !== 3'd3 || in_service !== 1'b1) begin
            n_errs++; $display("FAIL single_ack got %h/%0d/%b exp ff/3/1", req_n, isr_id, in_service);
        end
        eoi = 1;
        tick();
        eoi = 0;
        n_checks++;
        if (in_service !== 1'b0 || req_n !== 8'hFF || {req_n, in_service, isr_id, mask} !== model_vec()) begin
            n_errs++; $display("FAIL single_eoi got %h/%b exp ff/0", req_n, in_service);
        end
    endtask

    task automatic test_two_requests();
        do_reset();
        write_mask(8'h40);
        irq_n = ~8'h44;
        tick(); tick(); tick();
        irq_n = 8'hFF;
        tick(); tick(); tick();
        n_checks++;
        if (req_n !== 8'hFB) begin n_errs++; $display("FAIL two_masked got %h exp fb", req_n); end
        write_mask(8'h00);
        n_checks++;
        if (req_n !== 8'hBB) begin n_errs++; $display("FAIL two_unmask got %h exp bb", req_n); end
        ack = 1; ack_id_n = 3'b001;
        tick();
        ack = 0;
        n_checks++;
        if (req_n !== 8'hFF || isr_id !== 3'd6) begin
            n_errs++; $display("FAIL two_ack got %h/%0d exp ff/6", req_n, isr_id);
        end
        eoi = 1;
        tick();
        eoi = 0;
        n_checks++;
        if (req_n !== 8'hFB || in_service !== 1'b0) begin
            n_errs++; $display("FAIL two_eoi got %h/%b exp fb/0", req_n, in_service);
        end
    endtask

    task automatic test_collision();
        do_reset();
        write_mask(8'h00);
        irq_n[5] = 1'b0;
        tick(); tick(); tick();
        irq_n[5] = 1'b1;
        tick(); tick(); tick();
        irq_n[5] = 1'b0;
        repeat (SYNC_STAGES) tick();
        ack = 1; ack_id_n = 3'b010;      // capture of the new edge lands on this edge
        tick();
        ack = 0; irq_n[5] = 1'b1;
        n_checks++;
        if (in_service !== 1'b1 || isr_id !== 3'd5) begin
            n_errs++; $display("FAIL collide_ack got %b/%0d exp 1/5", in_service, isr_id);
        end
        eoi = 1;
        tick();
        eoi = 0;
        n_checks++;
        if (req_n !== 8'hDF) begin n_errs++; $display("FAIL collide_set_wins got %h exp df", req_n); end
    endtask

    task automatic test_level_vs_edge();
        logic [7:0] exp_after;
`ifdef IRQ_EDGE_TRIGGER_EN
        exp_after = 8'hFF;
`else
        exp_after = 8'hFE;
`endif
        do_reset();
        write_mask(8'h00);
        irq_n[0] = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (req_n !== 8'hFE) begin n_errs++; $display("FAIL level_req got %h exp fe", req_n); end
        ack = 1; ack_id_n = 3'b111;
        tick();
        ack = 0;
        tick(); tick();
        eoi = 1;
        tick();
        eoi = 0;
        n_checks++;
        if (req_n !== exp_after) begin
            n_errs++; $display("FAIL level_vs_edge got %h exp %h", req_n, exp_after);
        end
        irq_n = 8'hFF;
    endtask

    task automatic test_spurious_and_reset();
        do_reset();
        write_mask(8'h00);
        ack = 1; ack_id_n = 3'b000;
        tick();
        ack = 0;
        n_checks++;
        if (in_service !== 1'b0 || req_n !== 8'hFF) begin
            n_errs++; $display("FAIL ack_in_idle got %b/%h exp 0/ff", in_service, req_n);
        end
        irq_n[1] = 1'b0;
        tick(); tick(); tick();
        irq_n[1] = 1'b1;
        tick(); tick(); tick();
        eoi = 1;
        tick();
        eoi = 0;
        n_checks++;
        if (req_n !== 8'hFD || in_service !== 1'b0) begin
            n_errs++; $display("FAIL eoi_in_req got %h/%b exp fd/0", req_n, in_service);
        end
        ack = 1; ack_id_n = 3'b110;
        tick();
        ack = 0;
        irq_n[4] = 1'b0;
        rst = 1; ack = 1; eoi = 1;
        tick();
        rst = 0; ack = 0; eoi = 0; irq_n = 8'hFF;
        n_checks++;
        if (in_service !== 1'b0 || req_n !== 8'hFF || mask !== 8'hFF || isr_id !== 3'd0) begin
            n_errs++; $display("FAIL rst_in_service got %b/%h/%h/%0d exp 0/ff/ff/0", in_service, req_n, mask, isr_id);
        end
        write_mask(8'h00);
        n_checks++;
        if (req_n !== 8'hFF) begin n_errs++; $display("FAIL rst_pend_cleared got %h exp ff", req_n); end
    endtask

    task automatic test_random();
        logic [7:0] act;
        logic [19:0] got;
        int idx;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 7) == 0) irq_n[b] = ~irq_n[b];
            mask_we    = ($urandom_range(0, 7) == 0);
            mask_wdata = 8'($urandom) & 8'($urandom);
            act = m_pend & ~m_mask;
            idx = -1;
            for (int b = 7; b >= 0; b--)
                if (act[b] && idx < 0) idx = b;
            ack = ($urandom_range(0, 3) == 0);
            if (idx >= 0 && $urandom_range(0, 3) != 0) ack_id_n = ~3'(idx);
            else ack_id_n = 3'($urandom);
            eoi = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
            got = {req_n, in_service, isr_id, mask};
            n_checks++;
            if (got !== model_vec()) begin
                n_errs++;
                $display("FAIL random cycle %0d got %h exp %h", c, got, model_vec());
            end
        end
        rst = 0; ack = 0; eoi = 0; mask_we = 0;
    endtask

    initial begin
        rst = 1; irq_n = 8'hFF; mask_we = 0; mask_wdata = 8'h00;
        ack = 0; ack_id_n = 3'b000; eoi = 0;
        m_q.delete();
        for (int i = 0; i < SYNC_STAGES; i++) m_q.push_back(8'hFF);
        m_prev = 8'hFF; m_pend = 8'h00; m_mask = 8'hFF; m_st = 0; m_isr = 0;

        test_reset();
        test_single_request();
        test_two_requests();
        test_collision();
        test_level_vs_edge();
        test_spurious_and_reset();
        test_random();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule : tb_irq_request_latch
`default_nettype wire
